// File: rtl/commit_order_ring_pkg.sv
// Shared commit-ring types and default widths for dispatch/commit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package commit_order_ring_pkg;

  // Single-lane ring depth (log2) and ROB index width of the existing pipeline.
  localparam int COMMIT_RING_WIDTH = 4;
  localparam int ROB_WIDTH         = 6;

  // Default lane counts for the wide ring.
  localparam int N_DISPATCH = 2;
  localparam int N_COMMIT   = 2;

  // Commit tag carried through the ring; COMMIT_NULL marks an empty lane.
  typedef enum logic [2:0] {
    COMMIT_GPR    = 3'b000,
    COMMIT_FPR    = 3'b001,
    COMMIT_STORE  = 3'b010,
    COMMIT_BRANCH = 3'b011,
    COMMIT_CSR    = 3'b100,
    COMMIT_FENCE  = 3'b101,
    COMMIT_NULL   = 3'b110,
    COMMIT_EXC    = 3'b111
  } commit_ring_entry;

endpackage

// File: rtl/commit_order_ring_lane_popcount.sv
// Lane popcount plus thermometer (contiguous-from-lane-0) detector.
// Latency: purely combinational.
// Backpressure: none.
module lane_popcount #(
  parameter int N = 2
) (
  input  logic [N-1:0]             vec,
  output logic [$clog2(N+1)-1:0]   cnt,
  output logic                     contig
);

  localparam int CW = $clog2(N + 1);

  // Count set lanes and flag any set lane whose lower neighbour is clear.
  always_comb begin
    cnt    = '0;
    contig = 1'b1;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + CW'(vec[i]);
    end
    for (int i = 1; i < N; i++) begin
      if (vec[i] && !vec[i-1]) contig = 1'b0;
    end
  end

endmodule

// File: rtl/commit_order_ring.sv
// Multi-lane in-order commit ring: wide all-or-nothing dispatch push, wide head retire, flush.
// Latency: a pushed entry appears on out_* the cycle after the push; count/free registered.
// Backpressure: stall (comb) rejects the whole dispatch group when it exceeds registered free.
// Optional build macro COMMIT_RING_STATS_EN adds max_count and stall_cycles outputs.
module commit_order_ring
  import commit_order_ring_pkg::*;
#(
  parameter int DEPTH_WIDTH = COMMIT_RING_WIDTH,
  parameter int N_IN        = N_DISPATCH,
  parameter int N_OUT       = N_COMMIT
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_IN-1:0]                 in_valid,
  input  logic [N_IN-1:0][2:0]            in_type,
  output logic                            stall,
  output logic [DEPTH_WIDTH:0]            free,
  output logic [N_OUT-1:0]                out_valid,
  output logic [N_OUT-1:0][2:0]           out_type,
  input  logic [$clog2(N_OUT+1)-1:0]      out_ack,
  input  logic                            flush,
  output logic [DEPTH_WIDTH:0]            count
`ifdef COMMIT_RING_STATS_EN
  ,
  output logic [DEPTH_WIDTH:0]            max_count,
  output logic [31:0]                     stall_cycles
`endif
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam int PW    = DEPTH_WIDTH + 1;
  localparam int IW    = $clog2(N_IN + 1);
  localparam int AW    = $clog2(N_OUT + 1);

  if (DEPTH_WIDTH > ROB_WIDTH) begin : g_depth_check
    $error("commit_order_ring: DEPTH_WIDTH must not exceed ROB_WIDTH");
  end

  logic [2:0]             mem [DEPTH];
  logic [PW-1:0]          head;
  logic [PW-1:0]          tail;
  logic [IW-1:0]          n_push;
  logic                   in_contig;
  logic [AW-1:0]          n_live;
  logic                   live_contig;
  logic                   accept;
  logic                   push_en;
  logic [PW-1:0]          push_amt;
  logic [PW-1:0]          count_next;
  logic [DEPTH_WIDTH-1:0] wr_idx [N_IN];
  logic [DEPTH_WIDTH-1:0] rd_idx [N_OUT];

  lane_popcount #(.N(N_IN)) u_push_cnt (
    .vec    (in_valid),
    .cnt    (n_push),
    .contig (in_contig)
  );

  lane_popcount #(.N(N_OUT)) u_live_cnt (
    .vec    (out_valid),
    .cnt    (n_live),
    .contig (live_contig)
  );

  // Admission decision against pre-pop free; flush and reset win over any push.
  always_comb begin
    accept     = (PW'(n_push) <= free);
    stall      = !reset && !flush && !accept;
    push_en    = !reset && !flush && accept;
    push_amt   = push_en ? PW'(n_push) : '0;
    count_next = count + push_amt - PW'(out_ack);
    for (int i = 0; i < N_IN; i++) begin
      wr_idx[i] = tail[DEPTH_WIDTH-1:0] + DEPTH_WIDTH'(i);
    end
    for (int i = 0; i < N_OUT; i++) begin
      rd_idx[i] = head[DEPTH_WIDTH-1:0] + DEPTH_WIDTH'(i);
    end
  end

  // Head lanes come straight from registered state; empty lanes show COMMIT_NULL.
  always_comb begin
    for (int i = 0; i < N_OUT; i++) begin
      out_valid[i] = (count > PW'(i));
      out_type[i]  = out_valid[i] ? mem[rd_idx[i]] : COMMIT_NULL;
    end
  end

  // Pointer and occupancy update; flush and reset both empty the ring.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      free  <= PW'(DEPTH);
    end else begin
      head  <= head + PW'(out_ack);
      tail  <= tail + push_amt;
      count <= count_next;
      free  <= PW'(DEPTH) - count_next;
    end
  end

  // Storage write for accepted lanes; contents are intentionally left on flush.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_IN; i++) begin
      if (push_en && in_valid[i]) mem[wr_idx[i]] <= in_type[i];
    end
  end

`ifdef COMMIT_RING_STATS_EN
  // High-water mark and saturating stall counter; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      max_count    <= '0;
      stall_cycles <= '0;
    end else begin
      if (!flush && (count_next > max_count)) max_count <= count_next;
      if (stall && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

  a_in_contig:      assert property (@(posedge clk) disable iff (reset) in_contig);
  a_out_thermo:     assert property (@(posedge clk) disable iff (reset) live_contig);
  a_ack_le_live:    assert property (@(posedge clk) disable iff (reset) out_ack <= n_live);
  a_count_le_depth: assert property (@(posedge clk) disable iff (reset) count <= PW'(DEPTH));

endmodule
